// File: rtl/wb_commit_if.sv
// Writeback/commit bus: issue-side scoreboard inputs, execute results, regfile write ports, status.
// WB_BYPASS_EN adds the same-cycle writeback bypass read ports.
interface wb_commit_if #(
  parameter int unsigned DW   = 32,
  parameter int unsigned PCW  = 32,
  parameter int unsigned NREG = 32
);
  logic            stop;
  logic            iss1_valid, iss1_wen;
  logic [4:0]      iss1_rd;
  logic            iss2_valid, iss2_wen;
  logic [4:0]      iss2_rd;
  logic            ex1_valid, ex1_wen;
  logic [PCW-1:0]  ex1_pc;
  logic [4:0]      ex1_rd;
  logic [DW-1:0]   ex1_data;
  logic            ex2_valid, ex2_wen;
  logic [PCW-1:0]  ex2_pc;
  logic [4:0]      ex2_rd;
  logic [DW-1:0]   ex2_data;
  logic            rf_we1, rf_we2;
  logic [4:0]      rf_waddr1, rf_waddr2;
  logic [DW-1:0]   rf_wdata1, rf_wdata2;
  logic [NREG-1:0] busy;
  logic [1:0]      commit_num;
  logic [PCW-1:0]  commit_pc;
  logic [63:0]     retired;
`ifdef WB_BYPASS_EN
  logic [4:0]      byp_ra1, byp_ra2;
  logic            byp_hit1, byp_hit2;
  logic [DW-1:0]   byp_data1, byp_data2;
`endif

  modport master (
`ifdef WB_BYPASS_EN
    output byp_ra1, byp_ra2,
    input  byp_hit1, byp_hit2, byp_data1, byp_data2,
`endif
    output stop, iss1_valid, iss1_wen, iss1_rd, iss2_valid, iss2_wen, iss2_rd,
    output ex1_valid, ex1_wen, ex1_pc, ex1_rd, ex1_data,
    output ex2_valid, ex2_wen, ex2_pc, ex2_rd, ex2_data,
    input  rf_we1, rf_we2, rf_waddr1, rf_waddr2, rf_wdata1, rf_wdata2,
    input  busy, commit_num, commit_pc, retired
  );

  modport slave (
`ifdef WB_BYPASS_EN
    input  byp_ra1, byp_ra2,
    output byp_hit1, byp_hit2, byp_data1, byp_data2,
`endif
    input  stop, iss1_valid, iss1_wen, iss1_rd, iss2_valid, iss2_wen, iss2_rd,
    input  ex1_valid, ex1_wen, ex1_pc, ex1_rd, ex1_data,
    input  ex2_valid, ex2_wen, ex2_pc, ex2_rd, ex2_data,
    output rf_we1, rf_we2, rf_waddr1, rf_waddr2, rf_wdata1, rf_wdata2,
    output busy, commit_num, commit_pc, retired
  );
endinterface

// File: rtl/wb_commit.sv
// Dual-lane writeback/commit stage with pending-write scoreboard and retire counter.
// Optional feature macro: WB_BYPASS_EN (same-cycle writeback bypass to the issue stage).
module wb_commit #(
  parameter int unsigned DW   = 32,
  parameter int unsigned PCW  = 32,
  parameter int unsigned NREG = 32,
  parameter int unsigned CNTW = 2
) (
  input logic        clk,
  input logic        rst,
  wb_commit_if.slave bus
);

  logic            wb1_valid_q, wb1_wen_q, wb2_valid_q, wb2_wen_q;
  logic [PCW-1:0]  wb1_pc_q, wb2_pc_q;
  logic [4:0]      wb1_rd_q, wb2_rd_q;
  logic [DW-1:0]   wb1_data_q, wb2_data_q;
  logic [CNTW-1:0] cnt_q [NREG];
  logic [CNTW-1:0] cnt_d [NREG];
  logic [63:0]     retired_q;
  logic            live, wr1, wr2, same_rd;
  logic [1:0]      commit_num;

  function automatic logic [CNTW-1:0] hits(input logic v1, input logic [4:0] a1,
                                           input logic v2, input logic [4:0] a2,
                                           input logic [4:0] r);
    hits = CNTW'(v1 && (a1 == r)) + CNTW'(v2 && (a2 == r));
  endfunction

  always_ff @(posedge clk) begin
    if (rst) begin
      wb1_valid_q <= 1'b0;
      wb1_wen_q   <= 1'b0;
      wb1_pc_q    <= '0;
      wb1_rd_q    <= '0;
      wb1_data_q  <= '0;
      wb2_valid_q <= 1'b0;
      wb2_wen_q   <= 1'b0;
      wb2_pc_q    <= '0;
      wb2_rd_q    <= '0;
      wb2_data_q  <= '0;
      retired_q   <= '0;
      for (int unsigned r = 0; r < NREG; r++) cnt_q[r] <= '0;
    end else if (!bus.stop) begin
      wb1_valid_q <= bus.ex1_valid;
      wb1_wen_q   <= bus.ex1_wen;
      wb1_pc_q    <= bus.ex1_pc;
      wb1_rd_q    <= bus.ex1_rd;
      wb1_data_q  <= bus.ex1_data;
      wb2_valid_q <= bus.ex2_valid;
      wb2_wen_q   <= bus.ex2_wen;
      wb2_pc_q    <= bus.ex2_pc;
      wb2_rd_q    <= bus.ex2_rd;
      wb2_data_q  <= bus.ex2_data;
      retired_q   <= retired_q + 64'(commit_num);
      for (int unsigned r = 0; r < NREG; r++) cnt_q[r] <= cnt_d[r];
    end
  end

  // Decrements count every valid&wen lane, even the one suppressed by the same-rd rule.
  always_comb begin
    cnt_d[0] = '0;
    for (int unsigned r = 1; r < NREG; r++) begin
      cnt_d[r] = cnt_q[r]
               + hits(bus.iss1_valid && bus.iss1_wen, bus.iss1_rd,
                      bus.iss2_valid && bus.iss2_wen, bus.iss2_rd, 5'(r))
               - hits(wb1_valid_q && wb1_wen_q, wb1_rd_q,
                      wb2_valid_q && wb2_wen_q, wb2_rd_q, 5'(r));
    end
  end

  // Reset drops in-flight entries without writing or committing them.
  always_comb begin
    live    = !bus.stop && !rst;
    wr1     = wb1_valid_q && wb1_wen_q && (wb1_rd_q != 5'd0) && live;
    wr2     = wb2_valid_q && wb2_wen_q && (wb2_rd_q != 5'd0) && live;
    same_rd = wr1 && wr2 && (wb1_rd_q == wb2_rd_q);
    commit_num = live ? ({1'b0, wb1_valid_q} + {1'b0, wb2_valid_q}) : 2'd0;
  end

  always_comb begin
    bus.rf_we1     = wr1 && !same_rd;
    bus.rf_waddr1  = wb1_rd_q;
    bus.rf_wdata1  = wb1_data_q;
    bus.rf_we2     = wr2;
    bus.rf_waddr2  = wb2_rd_q;
    bus.rf_wdata2  = wb2_data_q;
    bus.commit_num = commit_num;
    bus.retired    = retired_q;
    bus.commit_pc  = '0;
    if (live && wb2_valid_q)      bus.commit_pc = wb2_pc_q;
    else if (live && wb1_valid_q) bus.commit_pc = wb1_pc_q;
    bus.busy = '0;
    for (int unsigned r = 1; r < NREG; r++) bus.busy[r] = |cnt_q[r];
  end

`ifdef WB_BYPASS_EN
  always_comb begin
    bus.byp_hit1  = 1'b0;
    bus.byp_data1 = '0;
    bus.byp_hit2  = 1'b0;
    bus.byp_data2 = '0;
    if (bus.byp_ra1 != 5'd0) begin
      if (bus.rf_we2 && (wb2_rd_q == bus.byp_ra1)) begin
        bus.byp_hit1  = 1'b1;
        bus.byp_data1 = wb2_data_q;
      end else if (bus.rf_we1 && (wb1_rd_q == bus.byp_ra1)) begin
        bus.byp_hit1  = 1'b1;
        bus.byp_data1 = wb1_data_q;
      end
    end
    if (bus.byp_ra2 != 5'd0) begin
      if (bus.rf_we2 && (wb2_rd_q == bus.byp_ra2)) begin
        bus.byp_hit2  = 1'b1;
        bus.byp_data2 = wb2_data_q;
      end else if (bus.rf_we1 && (wb1_rd_q == bus.byp_ra2)) begin
        bus.byp_hit2  = 1'b1;
        bus.byp_data2 = wb1_data_q;
      end
    end
  end
`endif

endmodule

// File: tb/tb_wb_commit.sv
// Directed self-checking bench for wb_commit; expected values are hand-computed per step.
module tb_wb_commit;
  logic clk = 1'b0;
  logic rst = 1'b1;
  int   n_checks = 0;
  int   n_fail   = 0;

  always #5 clk = ~clk;

  wb_commit_if #(.DW(32), .PCW(32), .NREG(32)) bus ();

  wb_commit #(.DW(32), .PCW(32), .NREG(32), .CNTW(2)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic clear_inputs();
    bus.stop = 1'b0;
    bus.iss1_valid = 1'b0; bus.iss1_wen = 1'b0; bus.iss1_rd = '0;
    bus.iss2_valid = 1'b0; bus.iss2_wen = 1'b0; bus.iss2_rd = '0;
    bus.ex1_valid = 1'b0; bus.ex1_wen = 1'b0; bus.ex1_pc = '0; bus.ex1_rd = '0;
    bus.ex1_data = '0;
    bus.ex2_valid = 1'b0; bus.ex2_wen = 1'b0; bus.ex2_pc = '0; bus.ex2_rd = '0;
    bus.ex2_data = '0;
`ifdef WB_BYPASS_EN
    bus.byp_ra1 = '0; bus.byp_ra2 = '0;
`endif
  endtask

  task automatic issue(input logic l1, input logic [4:0] rd1, input logic l2,
                       input logic [4:0] rd2);
    bus.iss1_valid = l1; bus.iss1_wen = l1; bus.iss1_rd = rd1;
    bus.iss2_valid = l2; bus.iss2_wen = l2; bus.iss2_rd = rd2;
  endtask

  task automatic ex1(input logic wen, input logic [4:0] rd, input logic [31:0] pc,
                     input logic [31:0] data);
    bus.ex1_valid = 1'b1; bus.ex1_wen = wen; bus.ex1_rd = rd; bus.ex1_pc = pc;
    bus.ex1_data = data;
  endtask

  task automatic ex2(input logic wen, input logic [4:0] rd, input logic [31:0] pc,
                     input logic [31:0] data);
    bus.ex2_valid = 1'b1; bus.ex2_wen = wen; bus.ex2_rd = rd; bus.ex2_pc = pc;
    bus.ex2_data = data;
  endtask

  initial begin
    clear_inputs();
    // Reset with random traffic on every input
    for (int i = 0; i < 2; i++) begin
      bus.stop = 1'($urandom);
      issue(1'($urandom), 5'($urandom), 1'($urandom), 5'($urandom));
      bus.ex1_valid = 1'($urandom); bus.ex1_wen = 1'($urandom); bus.ex1_rd = 5'($urandom);
      bus.ex2_valid = 1'($urandom); bus.ex2_wen = 1'($urandom); bus.ex2_rd = 5'($urandom);
      bus.ex1_data = 32'($urandom); bus.ex2_data = 32'($urandom);
      tick();
    end
    clear_inputs();
    #1;
    check("rst_we1", 64'(bus.rf_we1), 64'd0);
    check("rst_we2", 64'(bus.rf_we2), 64'd0);
    check("rst_busy", 64'(bus.busy), 64'd0);
    check("rst_retired", bus.retired, 64'd0);
    check("rst_commit_num", 64'(bus.commit_num), 64'd0);
    check("rst_commit_pc", 64'(bus.commit_pc), 64'd0);
    rst = 1'b0;
    tick();

    // Single lane-1 write to x5
    issue(1'b1, 5'd5, 1'b0, 5'd0);
    tick(); clear_inputs(); #1;
    check("t2_busy_issue", 64'(bus.busy), 64'h20);
    tick();
    ex1(1'b1, 5'd5, 32'h100, 32'hDEAD_BEEF);
    tick(); clear_inputs(); #1;
    check("t2_we1", 64'(bus.rf_we1), 64'd1);
    check("t2_waddr1", 64'(bus.rf_waddr1), 64'd5);
    check("t2_wdata1", 64'(bus.rf_wdata1), 64'hDEAD_BEEF);
    check("t2_we2", 64'(bus.rf_we2), 64'd0);
    check("t2_busy_wb", 64'(bus.busy), 64'h20);
    check("t2_commit_num", 64'(bus.commit_num), 64'd1);
    check("t2_commit_pc", 64'(bus.commit_pc), 64'h100);
    tick();
    check("t2_busy_clr", 64'(bus.busy), 64'd0);
    check("t2_we1_off", 64'(bus.rf_we1), 64'd0);
    check("t2_retired", bus.retired, 64'd1);

    // Both lanes to x7: lane 2 wins the port
    issue(1'b1, 5'd7, 1'b1, 5'd7);
    tick(); clear_inputs(); #1;
    check("t3_busy_issue", 64'(bus.busy), 64'h80);
    ex1(1'b1, 5'd7, 32'h200, 32'd1);
    ex2(1'b1, 5'd7, 32'h204, 32'd2);
    tick(); clear_inputs(); #1;
    check("t3_we1", 64'(bus.rf_we1), 64'd0);
    check("t3_we2", 64'(bus.rf_we2), 64'd1);
    check("t3_waddr2", 64'(bus.rf_waddr2), 64'd7);
    check("t3_wdata2", 64'(bus.rf_wdata2), 64'd2);
    check("t3_commit_num", 64'(bus.commit_num), 64'd2);
    check("t3_commit_pc", 64'(bus.commit_pc), 64'h204);
    tick();
    check("t3_busy_clr", 64'(bus.busy), 64'd0);
    check("t3_retired", bus.retired, 64'd3);
    // Two pending on x7, retired one at a time
    issue(1'b1, 5'd7, 1'b1, 5'd7);
    tick(); clear_inputs();
    ex1(1'b1, 5'd7, 32'h208, 32'd3);
    tick(); clear_inputs(); #1;
    check("t3b_we1", 64'(bus.rf_we1), 64'd1);
    tick();
    check("t3b_busy_half", 64'(bus.busy), 64'h80);
    check("t3b_retired", bus.retired, 64'd4);
    ex2(1'b1, 5'd7, 32'h20C, 32'd4);
    tick(); clear_inputs();
    tick();
    check("t3b_busy_clr", 64'(bus.busy), 64'd0);
    check("t3b_retired2", bus.retired, 64'd5);

    // x0 write suppressed; wen=0 commit still counted
    ex1(1'b1, 5'd0, 32'h300, 32'h1234);
    tick(); clear_inputs(); #1;
    check("t4_we1_x0", 64'(bus.rf_we1), 64'd0);
    check("t4_commit_num1", 64'(bus.commit_num), 64'd1);
    check("t4_commit_pc1", 64'(bus.commit_pc), 64'h300);
    check("t4_busy", 64'(bus.busy), 64'd0);
    ex2(1'b0, 5'd3, 32'h304, 32'd9);
    tick(); clear_inputs(); #1;
    check("t4_we2_nowen", 64'(bus.rf_we2), 64'd0);
    check("t4_commit_num2", 64'(bus.commit_num), 64'd1);
    check("t4_commit_pc2", 64'(bus.commit_pc), 64'h304);
    check("t4_retired", bus.retired, 64'd6);
    tick();
    check("t4_retired2", bus.retired, 64'd7);

    // Stall for three cycles with both wb entries valid
    issue(1'b1, 5'd10, 1'b1, 5'd11);
    tick(); clear_inputs();
    ex1(1'b1, 5'd10, 32'h400, 32'hA);
    ex2(1'b1, 5'd11, 32'h404, 32'hB);
    tick(); clear_inputs();
    bus.stop = 1'b1;
    issue(1'b1, 5'd12, 1'b0, 5'd0);
    #1;
    check("t5_we1_stall", 64'(bus.rf_we1), 64'd0);
    check("t5_we2_stall", 64'(bus.rf_we2), 64'd0);
    check("t5_commit_stall", 64'(bus.commit_num), 64'd0);
    check("t5_pc_stall", 64'(bus.commit_pc), 64'd0);
    for (int i = 0; i < 3; i++) begin
      tick();
      check("t5_retired_frozen", bus.retired, 64'd7);
      check("t5_busy_frozen", 64'(bus.busy), 64'hC00);
      check("t5_we2_frozen", 64'(bus.rf_we2), 64'd0);
    end
    clear_inputs();
    #1;
    check("t5_we1_rel", 64'(bus.rf_we1), 64'd1);
    check("t5_waddr1_rel", 64'(bus.rf_waddr1), 64'd10);
    check("t5_we2_rel", 64'(bus.rf_we2), 64'd1);
    check("t5_wdata2_rel", 64'(bus.rf_wdata2), 64'hB);
    check("t5_commit_rel", 64'(bus.commit_num), 64'd2);
    check("t5_pc_rel", 64'(bus.commit_pc), 64'h404);
    tick();
    check("t5_we1_once", 64'(bus.rf_we1), 64'd0);
    check("t5_we2_once", 64'(bus.rf_we2), 64'd0);
    check("t5_retired", bus.retired, 64'd9);
    check("t5_busy_clr", 64'(bus.busy), 64'd0);

    // Reset while a write sits in wb
    issue(1'b1, 5'd13, 1'b0, 5'd0);
    tick(); clear_inputs();
    ex1(1'b1, 5'd13, 32'h600, 32'h77);
    tick(); clear_inputs();
    rst = 1'b1;
    #1;
    check("rst_mid_we1", 64'(bus.rf_we1), 64'd0);
    check("rst_mid_commit", 64'(bus.commit_num), 64'd0);
    check("rst_mid_busy", 64'(bus.busy), 64'h2000);
    tick();
    rst = 1'b0;
    #1;
    check("rst_mid_busy_clr", 64'(bus.busy), 64'd0);
    check("rst_mid_retired", bus.retired, 64'd0);
    check("rst_mid_we1_after", 64'(bus.rf_we1), 64'd0);

`ifdef WB_BYPASS_EN
    issue(1'b0, 5'd0, 1'b1, 5'd9);
    tick(); clear_inputs();
    ex2(1'b1, 5'd9, 32'h500, 32'h55);
    tick(); clear_inputs();
    bus.byp_ra1 = 5'd9;
    bus.byp_ra2 = 5'd0;
    #1;
    check("t6_hit1", 64'(bus.byp_hit1), 64'd1);
    check("t6_data1", 64'(bus.byp_data1), 64'h55);
    check("t6_hit2_x0", 64'(bus.byp_hit2), 64'd0);
    bus.byp_ra2 = 5'd8;
    #1;
    check("t6_hit2_miss", 64'(bus.byp_hit2), 64'd0);
    tick();
`endif

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end
endmodule
